// File: rtl/regfile_pkg.sv
// Shared definitions for the writeback path into the 1024x72 register file.
// Provides address/data widths and the queued writeback entry type.
package regfile_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 72;
    localparam int NUM_REGS = 1024;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries with occupancy flags.
// Ports: clk/rst_n, i_push/i_entry tail write, i_pop head advance,
// o_head head entry, o_count/o_full/o_empty occupancy,
// o_valid/o_addr per-slot view for hazard compare.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  wb_entry_t         i_entry,
    input  logic              i_pop,
    output wb_entry_t         o_head,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic [DEPTH-1:0]  o_valid,
    output logic [ADDR_W-1:0] o_addr [DEPTH]
);

    wb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is deliberately left out of reset; o_valid masks stale slots.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the head is below occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        logic [PW-1:0] w_off;
        assign w_off      = PW'(g) - r_rd_ptr;
        assign o_valid[g] = ({1'b0, w_off} < r_count);
        assign o_addr[g]  = r_mem[g].addr;
    end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback queue feeding the regfile write port, arbitrating read slots.
// Ports: execute handshake (in_*), decode read/hazard (rd_*, hazard*),
// regfile write (write, reg_r_address, result_in), occupancy (count/full/empty).
module writeback_buffer
    import regfile_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int STARVE_MAX = 3,
    parameter  int ADDR_W     = regfile_pkg::ADDR_W,
    parameter  int DATA_W     = regfile_pkg::DATA_W,
    localparam int CW         = $clog2(DEPTH) + 1,
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_grant,
    output logic              hazard1,
    output logic              hazard2,
    output logic              write,
    output logic [ADDR_W-1:0] reg_r_address,
    output logic [DATA_W-1:0] result_in,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    wb_entry_t         w_in_entry;
    wb_entry_t         w_head;
    logic [DEPTH-1:0]  w_valid;
    logic [ADDR_W-1:0] w_addr [DEPTH];
    logic              w_push;
    logic              w_force;
    logic              w_hz1;
    logic              w_hz2;
    logic [SW-1:0]     r_starve;

    assign w_in_entry.addr = in_addr;
    assign w_in_entry.data = in_data;
    assign in_ready        = !full;
    assign w_push          = in_valid && in_ready;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_entry (w_in_entry),
        .i_pop   (write),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty),
        .o_valid (w_valid),
        .o_addr  (w_addr)
    );

    // Reads win unless the queue is full or reads have hogged the port.
    assign w_force  = full || (r_starve == SW'(STARVE_MAX));
    assign write    = !empty && (!rd_req || w_force);
    assign rd_grant = rd_req && !write;

    assign reg_r_address = empty ? '0 : w_head.addr;
    assign result_in     = empty ? '0 : w_head.data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (write || empty) begin
            r_starve <= '0;
        end else if (rd_grant && (r_starve != SW'(STARVE_MAX))) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // The entry being pushed is already pending for decode's purposes.
    always_comb begin
        w_hz1 = w_push && (in_addr == rd_addr1);
        w_hz2 = w_push && (in_addr == rd_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_addr[i] == rd_addr1)) begin
                w_hz1 = 1'b1;
            end
            if (w_valid[i] && (w_addr[i] == rd_addr2)) begin
                w_hz2 = 1'b1;
            end
        end
    end

    assign hazard1 = w_hz1;
    assign hazard2 = w_hz2;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: per-cycle vector table plus
// hand sequences for regfile contents and mid-operation reset.
module tb_writeback_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_addr;
    logic [71:0] in_data;
    logic        rd_req;
    logic [9:0]  rd_addr1;
    logic [9:0]  rd_addr2;
    logic        rd_grant;
    logic        hazard1;
    logic        hazard2;
    logic        write;
    logic [9:0]  reg_r_address;
    logic [71:0] result_in;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    typedef struct {
        logic        iv;
        logic [9:0]  ia;
        logic [71:0] id;
        logic        rq;
        logic [9:0]  a1;
        logic [9:0]  a2;
        logic        rdy;
        logic        gnt;
        logic        wr;
        logic        h1;
        logic        h2;
        logic [9:0]  ea;
        logic [71:0] ed;
        logic [2:0]  ec;
    } vec_t;

    vec_t        vt[$];
    int          n_chk;
    int          n_pass;
    int          n_wr;
    int          w0;
    logic [71:0] rf [0:1023];

    writeback_buffer dut (
        .clk           (clk),
        .reset         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .rd_req        (rd_req),
        .rd_addr1      (rd_addr1),
        .rd_addr2      (rd_addr2),
        .rd_grant      (rd_grant),
        .hazard1       (hazard1),
        .hazard2       (hazard2),
        .write         (write),
        .reg_r_address (reg_r_address),
        .result_in     (result_in),
        .count         (count),
        .full          (full),
        .empty         (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: samples the write port at each rising edge.
    always @(posedge clk) begin
        if (write === 1'b1) begin
            rf[reg_r_address] <= result_in;
            n_wr <= n_wr + 1;
        end
    end

    function automatic vec_t mk(int iv, int ia, int id, int rq,
                                int a1, int a2, int rdy, int gnt,
                                int wr, int h1, int h2, int ea,
                                int ed, int ec);
        vec_t v;
        v.iv  = iv[0];
        v.ia  = ia[9:0];
        v.id  = {40'd0, id};
        v.rq  = rq[0];
        v.a1  = a1[9:0];
        v.a2  = a2[9:0];
        v.rdy = rdy[0];
        v.gnt = gnt[0];
        v.wr  = wr[0];
        v.h1  = h1[0];
        v.h2  = h2[0];
        v.ea  = ea[9:0];
        v.ed  = {40'd0, ed};
        v.ec  = ec[2:0];
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [71:0] act,
                       input logic [71:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s #%0d: got %0h expected %0h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        in_valid = v.iv;
        in_addr  = v.ia;
        in_data  = v.id;
        rd_req   = v.rq;
        rd_addr1 = v.a1;
        rd_addr2 = v.a2;
    endtask

    task automatic check_vec(input int k, input vec_t v);
        chk("in_ready", k, 72'(in_ready), 72'(v.rdy));
        chk("rd_grant", k, 72'(rd_grant), 72'(v.gnt));
        chk("write",    k, 72'(write),    72'(v.wr));
        chk("hazard1",  k, 72'(hazard1),  72'(v.h1));
        chk("hazard2",  k, 72'(hazard2),  72'(v.h2));
        chk("reg_addr", k, 72'(reg_r_address), 72'(v.ea));
        chk("result",   k, result_in,     v.ed);
        chk("count",    k, 72'(count),    72'(v.ec));
        chk("full",     k, 72'(full),     72'(v.ec == 3'd4));
        chk("empty",    k, 72'(empty),    72'(v.ec == 3'd0));
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        n_wr     = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        rd_req   = 1'b1;
        rd_addr1 = '0;
        rd_addr2 = '0;

        // Reset state
        #2;
        chk("rst_write",  0, 72'(write),    72'(0));
        chk("rst_grant",  0, 72'(rd_grant), 72'(1));
        chk("rst_count",  0, 72'(count),    72'(0));
        chk("rst_empty",  0, 72'(empty),    72'(1));
        chk("rst_full",   0, 72'(full),     72'(0));
        chk("rst_ready",  0, 72'(in_ready), 72'(1));
        chk("rst_addr",   0, 72'(reg_r_address), 72'(0));
        chk("rst_data",   0, result_in,     72'(0));
        chk("rst_h1",     0, 72'(hazard1),  72'(0));
        chk("rst_h2",     0, 72'(hazard2),  72'(0));

        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rd_req = 1'b0;

        //       iv ia  id    rq a1 a2  rdy gnt wr h1 h2  ea  ed    ec
        // single push drains next cycle
        vt.push_back(mk(1, 5, 'hA5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 5, 0, 1, 0, 1, 1, 0, 5, 'hA5, 1));
        vt.push_back(mk(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // fill under continuous reads, then forced drain
        vt.push_back(mk(1, 10, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 11, 2, 1, 0, 0, 1, 1, 0, 0, 0, 10, 1, 1));
        vt.push_back(mk(1, 12, 3, 1, 0, 0, 1, 1, 0, 0, 0, 10, 1, 2));
        vt.push_back(mk(1, 13, 4, 1, 0, 0, 1, 1, 0, 0, 0, 10, 1, 3));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 10, 1, 4));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 11, 2, 3));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 12, 3, 2));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 13, 4, 1));
        // starvation limit with one entry
        vt.push_back(mk(1, 20, 'h14, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 20, 'h14, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 20, 'h14, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 20, 'h14, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 20, 'h14, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // hazard on addr 7
        vt.push_back(mk(1, 7, 'h77, 1, 7, 8, 1, 1, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 7, 8, 1, 1, 0, 1, 0, 7, 'h77, 1));
        vt.push_back(mk(0, 0, 0, 0, 7, 8, 1, 0, 1, 1, 0, 7, 'h77, 1));
        vt.push_back(mk(0, 0, 0, 0, 7, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        // WAW on addr 9
        vt.push_back(mk(1, 9, 1, 1, 9, 8, 1, 1, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 9, 2, 1, 9, 8, 1, 1, 0, 1, 0, 9, 1, 1));
        vt.push_back(mk(0, 0, 0, 0, 9, 8, 1, 0, 1, 1, 0, 9, 1, 2));
        vt.push_back(mk(0, 0, 0, 0, 9, 8, 1, 0, 1, 1, 0, 9, 2, 1));
        vt.push_back(mk(0, 0, 0, 0, 9, 8, 1, 0, 0, 0, 0, 0, 0, 0));
        // push and pop in the same cycle; stale slot must not alias
        vt.push_back(mk(1, 30, 'h30, 0, 0, 30, 1, 0, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 31, 'h31, 0, 0, 30, 1, 0, 1, 0, 1, 30, 'h30, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 30, 1, 0, 1, 0, 0, 31, 'h31, 1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < vt.size(); k++) begin
            @(negedge clk);
            apply(vt[k]);
            #1;
            check_vec(k, vt[k]);
        end

        // Regfile contents after the table
        @(negedge clk);
        #1;
        chk("rf5",    0, rf[5],  72'hA5);
        chk("rf13",   0, rf[13], 72'h4);
        chk("rf7",    0, rf[7],  72'h77);
        chk("rf9",    0, rf[9],  72'h2);
        chk("n_wr",   0, 72'(n_wr), 72'(11));

        // Mid-operation reset with three entries queued
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 10'd40;
        in_data  = 72'h40;
        rd_req   = 1'b1;
        rd_addr1 = 10'd40;
        rd_addr2 = 10'd0;
        @(negedge clk);
        in_addr = 10'd41;
        @(negedge clk);
        in_addr = 10'd42;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mr_count", 1, 72'(count),   72'(3));
        chk("mr_write", 1, 72'(write),   72'(0));
        chk("mr_h1",    1, 72'(hazard1), 72'(1));
        w0 = n_wr;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_write", 2, 72'(write),    72'(0));
        chk("mr_count", 2, 72'(count),    72'(0));
        chk("mr_empty", 2, 72'(empty),    72'(1));
        chk("mr_ready", 2, 72'(in_ready), 72'(1));
        chk("mr_grant", 2, 72'(rd_grant), 72'(1));
        chk("mr_h1",    2, 72'(hazard1),  72'(0));
        chk("mr_addr",  2, 72'(reg_r_address), 72'(0));
        chk("mr_data",  2, result_in,     72'(0));
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("mr_write", 3, 72'(write), 72'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_write", k, 72'(write), 72'(0));
            chk("post_count", k, 72'(count), 72'(0));
        end
        chk("mr_no_wr", 0, 72'(n_wr), 72'(w0));

        // Queue works normally after reset
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 10'd50;
        in_data  = 72'h55;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("post_wr",   0, 72'(write), 72'(1));
        chk("post_addr", 0, 72'(reg_r_address), 72'(50));
        chk("post_data", 0, result_in, 72'h55);
        @(negedge clk);
        #1;
        chk("rf50", 0, rf[50], 72'h55);
        chk("rf40", 0, 72'(rf[40] === 72'h40), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
